// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants, state codes and Booth decode for the iterative multiplier
package mul_pkg;

    localparam int XLEN  = 64;
    localparam int NDIG  = (XLEN + 2) / 2;
    localparam int CNT_W = 6;

    // Controller state codes
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Radix-4 Booth digit decoded into sign / zero / magnitude-select flags
    typedef struct packed {
        logic neg;
        logic zero;
        logic one;
        logic two;
    } booth_dec_t;

    // 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M
    function automatic booth_dec_t booth_decode(input logic [2:0] triplet);
        booth_dec_t d;
        d.zero = (triplet == 3'b000) || (triplet == 3'b111);
        d.two  = (triplet == 3'b011) || (triplet == 3'b100);
        d.one  = !d.zero && !d.two;
        d.neg  = triplet[2] && !d.zero;
        return d;
    endfunction

endpackage

// File: rtl/mul_pp128.sv
// rtl/mul_pp128.sv - Booth partial-product selector, negation completed by the adder carry-in
module mul_pp128
    import mul_pkg::*;
(
    input  logic [2:0]        triplet,
    input  logic [2*XLEN-1:0] mcand,
    output logic [2*XLEN-1:0] pp,
    output logic              cin
);

    booth_dec_t        dec;
    logic [2*XLEN-1:0] mag;

    // Select 0/M/2M, then one's-complement for negative digits; the +1 goes out as cin
    always_comb begin
        dec = booth_decode(triplet);
        mag = '0;
        if (dec.zero) begin
            mag = '0;
        end else if (dec.two) begin
            mag = {mcand[2*XLEN-2:0], 1'b0};
        end else if (dec.one) begin
            mag = mcand;
        end
        pp  = dec.neg ? ~mag : mag;
        cin = dec.neg;
    end

endmodule

// File: rtl/mul_iter_ctrl.sv
// rtl/mul_iter_ctrl.sv - sequential radix-4 Booth multiplier controller, one digit per cycle
module mul_iter_ctrl
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                mul_valid,
    output logic                mul_ready,
    input  logic                x_signed,
    input  logic                y_signed,
    input  logic [XLEN-1:0]     x,
    input  logic [XLEN-1:0]     y,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*XLEN-1:0]   result
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    // {ext2(y), y, 1'b0}: the extra low zero seeds the first Booth triplet
    logic [XLEN+2:0]   mplr;
    logic [2*XLEN-1:0] pp;
    logic              pp_cin;
    logic              accept;
    logic              last_digit;

    mul_pp128 u_pp (
        .triplet (mplr[2:0]),
        .mcand   (mcand),
        .pp      (pp),
        .cin     (pp_cin)
    );

    assign accept     = (state == IDLE) && mul_valid && !flush;
    assign last_digit = (cnt == CNT_W'(NDIG - 1));
    assign mul_ready  = (state == IDLE);
    assign out_valid  = (state == DONE);
    // acc is frozen outside CALC, so the result holds steady under backpressure
    assign result     = acc;

    // FSM, operand shift registers, digit counter and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= x_signed ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
                        mplr  <= {{2{y_signed && y[XLEN-1]}}, y, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        // Wraps modulo 2^128, which is exact for every signedness mix
                        acc   <= acc + pp + {{(2*XLEN-1){1'b0}}, pp_cin};
                        mcand <= {mcand[2*XLEN-3:0], 2'b00};
                        mplr  <= {{2{mplr[XLEN+2]}}, mplr[XLEN+2:2]};
                        cnt   <= cnt + 1'b1;
                        if (last_digit) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// tb/tb_mul_iter_ctrl.sv - self-checking bench for the iterative Booth multiplier controller
module tb_mul_iter_ctrl;
    import mul_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mul_valid = 1'b0;
    logic         x_signed = 1'b0;
    logic         y_signed = 1'b0;
    logic [63:0]  x = '0;
    logic [63:0]  y = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic         mul_ready;
    logic         out_valid;
    logic [127:0] result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .x_signed  (x_signed),
        .y_signed  (y_signed),
        .x         (x),
        .y         (y),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Reference product: extend both operands to 128 bits and multiply modulo 2^128
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic as, input logic bs);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = as ? {{64{a[63]}}, a} : {64'd0, a};
        eb = bs ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at the negedge after accept
    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input logic as, input logic bs, input string tag);
        mul_valid = 1'b1;
        x = a;
        y = b;
        x_signed = as;
        y_signed = bs;
        check($sformatf("%s_accept_ready", tag), 128'(mul_ready), 128'd1);
        @(negedge clk);
        mul_valid = 1'b0;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        x_signed = 1'($urandom);
        y_signed = 1'($urandom);
    endtask

    // Counts cycles after accept until out_valid, noting any mul_ready while busy
    task automatic wait_valid(output int lat, output bit rdy_bad);
        lat = 1;
        rdy_bad = 1'b0;
        while (!out_valid && lat < 60) begin
            if (mul_ready) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic as,
                         input logic bs, input logic [127:0] exp, input int bp,
                         input string tag);
        int           lat;
        bit           rdy_bad;
        bit           stable;
        logic [127:0] held;
        start_op(a, b, as, bs, tag);
        wait_valid(lat, rdy_bad);
        check($sformatf("%s_latency", tag), 128'(lat), 128'd34);
        check($sformatf("%s_busy_ready", tag), 128'(rdy_bad), 128'd0);
        check($sformatf("%s_result", tag), result, exp);
        check($sformatf("%s_done_ready", tag), 128'(mul_ready), 128'd0);
        held = result;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!out_valid || result !== held) stable = 1'b0;
        end
        if (bp > 0) check($sformatf("%s_hold", tag), 128'(stable), 128'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s_drop_valid", tag), 128'(out_valid), 128'd0);
        check($sformatf("%s_idle_ready", tag), 128'(mul_ready), 128'd1);
    endtask

    initial begin
        int           lat;
        bit           rdy_bad;
        bit           seen;
        logic [63:0]  ra;
        logic [63:0]  rb;
        logic         rs_a;
        logic         rs_b;

        repeat (2) @(negedge clk);
        check("reset_ready", 128'(mul_ready), 128'd1);
        check("reset_valid", 128'(out_valid), 128'd0);
        check("reset_result", result, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(64'd3, 64'd5, 1'b1, 1'b1, 128'd15, 0, "s_3x5");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 128'd1, 0, "s_m1xm1");
        do_op(-64'sd7, 64'd3, 1'b1, 1'b1,
              {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB}, 2, "s_m7x3");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
              {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, 10, "u_maxsq");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0,
              {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}, 1, "su_m1x2");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0,
              {64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE}, 0, "uu_m1x2");
        do_op(64'd0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 128'd0, 0, "zero_x");

        // flush at cnt=10 aborts the operation
        start_op(64'd5, 64'd7, 1'b0, 1'b0, "flush_calc");
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_ready", 128'(mul_ready), 128'd1);
        check("flush_calc_valid", 128'(out_valid), 128'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_calc_no_valid", 128'(seen), 128'd0);

        // flush in IDLE blocks acceptance
        mul_valid = 1'b1;
        flush = 1'b1;
        x = 64'd9;
        y = 64'd9;
        @(negedge clk);
        mul_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_blocked", 128'(mul_ready), 128'd1);

        do_op(64'd2, 64'd2, 1'b0, 1'b0, 128'd4, 0, "after_flush_2x2");

        // flush in DONE wins over out_ready and discards the result
        start_op(64'd11, 64'd13, 1'b0, 1'b0, "flush_done");
        wait_valid(lat, rdy_bad);
        check("flush_done_latency", 128'(lat), 128'd34);
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        flush = 1'b0;
        check("flush_done_valid", 128'(out_valid), 128'd0);
        check("flush_done_ready", 128'(mul_ready), 128'd1);

        // asynchronous reset mid-CALC
        start_op(64'h1_0000_0001, 64'h77, 1'b0, 1'b0, "rst_calc");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_calc_ready", 128'(mul_ready), 128'd1);
        check("rst_calc_valid", 128'(out_valid), 128'd0);
        check("rst_calc_result", result, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_calc_no_valid", 128'(seen), 128'd0);

        // randomized operands against the reference model
        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) ra = 64'h8000_0000_0000_0000;
            if (i == 1) rb = 64'h8000_0000_0000_0000;
            rs_a = 1'($urandom);
            rs_b = 1'($urandom);
            do_op(ra, rb, rs_a, rs_b, ref_mul(ra, rb, rs_a, rs_b),
                  int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
